// File: rtl/adder_pipe_pkg.sv
// Shared types and helpers for the chunked pipelined adder.
package adder_pipe_pkg;

  localparam int STATS_W = 32;

  // Per-stage control that travels with each transaction.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } stage_ctl_t;

  function automatic int num_stages(input int data_width, input int chunk_w);
    return (chunk_w > 0) ? data_width / chunk_w : 0;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One CHUNK_W-bit slice of the ripple-chunk adder with registered carry/valid.
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter int CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  stage_ctl_t         ctl_in,
  input  logic [CHUNK_W-1:0] a_chunk,
  input  logic [CHUNK_W-1:0] b_chunk,
  output stage_ctl_t         ctl_out,
  output logic [CHUNK_W-1:0] s_chunk
);

  logic [CHUNK_W:0] add;

  assign add = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_W{1'b0}}, ctl_in.carry};

  // Data only moves with a valid transaction, so idle-cycle garbage never lands here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_out <= '0;
      s_chunk <= '0;
    end else begin
      ctl_out.valid <= ctl_in.valid;
      if (ctl_in.valid) begin
        ctl_out.carry <= add[CHUNK_W];
        ctl_out.a_msb <= ctl_in.a_msb;
        ctl_out.b_msb <= ctl_in.b_msb;
        s_chunk       <= add[CHUNK_W-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined ripple-chunk adder: chunk k is summed in stage k, latency NUM_STAGES.
// Optional ADDER_PIPE_STATS_EN adds saturating transaction/overflow counters.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CHUNK_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  ovf,
  input  logic                  stats_clr,
  output logic [STATS_W-1:0]    txn_cnt,
  output logic [STATS_W-1:0]    ovf_cnt
);

  localparam int NUM_STAGES = num_stages(DATA_WIDTH, CHUNK_W);

  if (CHUNK_W < 1 || DATA_WIDTH % CHUNK_W != 0) begin : g_bad_cfg
    $error("adder_pipe: DATA_WIDTH (%0d) must be a multiple of CHUNK_W (%0d)", DATA_WIDTH, CHUNK_W);
  end

  stage_ctl_t [NUM_STAGES-1:0]              ctl_in;
  stage_ctl_t [NUM_STAGES-1:0]              ctl;
  logic       [NUM_STAGES-1:0][CHUNK_W-1:0] s;

  // Each stage k keeps only the operand chunks not yet consumed (a_rem/b_rem)
  // and the sum chunks already produced (acc), so widths shrink/grow per stage.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [DATA_WIDTH-k*CHUNK_W-1:0] a_rem;
    logic [DATA_WIDTH-k*CHUNK_W-1:0] b_rem;
    logic [(k+1)*CHUNK_W-1:0]        acc;

    if (k == 0) begin : g_head
      assign a_rem     = a;
      assign b_rem     = b;
      assign ctl_in[0] = '{valid: valid_in, carry: cin,
                           a_msb: a[DATA_WIDTH-1], b_msb: b[DATA_WIDTH-1]};
      assign acc       = s[0];
    end else begin : g_tail
      logic [k*CHUNK_W-1:0] lo_q;

      assign ctl_in[k] = ctl[k-1];
      assign acc       = {s[k], lo_q};

      // Operand skew loads with stage k-1; de-skew loads with stage k so the
      // whole sum changes on a single edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem <= '0;
          b_rem <= '0;
          lo_q  <= '0;
        end else begin
          if (ctl_in[k-1].valid) begin
            a_rem <= g_stage[k-1].a_rem[DATA_WIDTH-(k-1)*CHUNK_W-1:CHUNK_W];
            b_rem <= g_stage[k-1].b_rem[DATA_WIDTH-(k-1)*CHUNK_W-1:CHUNK_W];
          end
          if (ctl_in[k].valid) lo_q <= g_stage[k-1].acc;
        end
      end
    end

    adder_pipe_stage #(.CHUNK_W(CHUNK_W)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctl_in  (ctl_in[k]),
      .a_chunk (a_rem[CHUNK_W-1:0]),
      .b_chunk (b_rem[CHUNK_W-1:0]),
      .ctl_out (ctl[k]),
      .s_chunk (s[k])
    );
  end

  assign valid_out = ctl[NUM_STAGES-1].valid;
  assign cout      = ctl[NUM_STAGES-1].carry;
  assign sum       = g_stage[NUM_STAGES-1].acc;
  assign ovf       = (ctl[NUM_STAGES-1].a_msb == ctl[NUM_STAGES-1].b_msb) &&
                     (sum[DATA_WIDTH-1] != ctl[NUM_STAGES-1].a_msb);

`ifdef ADDER_PIPE_STATS_EN
  logic [STATS_W-1:0] txn_q, ovf_q;

  // Clear has priority over a same-cycle increment; both counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_q <= '0;
      ovf_q <= '0;
    end else if (stats_clr) begin
      txn_q <= '0;
      ovf_q <= '0;
    end else if (valid_out) begin
      if (txn_q != '1)        txn_q <= txn_q + STATS_W'(1);
      if (ovf && ovf_q != '1) ovf_q <= ovf_q + STATS_W'(1);
    end
  end

  assign txn_cnt = txn_q;
  assign ovf_cnt = ovf_q;
`else
  logic stats_clr_unused;
  assign stats_clr_unused = stats_clr;
  assign txn_cnt = '0;
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (32-bit, 8-bit chunks, latency 4); honours ADDER_PIPE_STATS_EN.
module tb_adder_pipe;
  localparam int DW = 32;
  localparam int CW = 8;
`ifdef ADDER_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          valid_in = 1'b0, cin = 1'b0, stats_clr = 1'b0;
  logic [DW-1:0] a = '0, b = '0;
  logic          valid_out, cout, ovf;
  logic [DW-1:0] sum;
  logic [31:0]   txn_cnt, ovf_cnt;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  adder_pipe #(.DATA_WIDTH(DW), .CHUNK_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .cin(cin),
    .valid_out(valid_out), .sum(sum), .cout(cout), .ovf(ovf),
    .stats_clr(stats_clr), .txn_cnt(txn_cnt), .ovf_cnt(ovf_cnt)
  );

  // Reference model: inputs wait in a 4-deep history, results from plain arithmetic.
  typedef struct { logic v; logic [31:0] a, b; logic c; } rec_t;
  rec_t        hist[$];
  logic        e_vld, e_cout, e_ovf;
  logic [31:0] e_sum, e_txn, e_ovfc;

  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] u;
    longint      sx;
    u  = {1'b0, x} + {1'b0, y} + {32'd0, c};
    sx = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    return {!((sx >>> 31) == 0 || (sx >>> 31) == -1), u[32], u[31:0]};
  endfunction

  task automatic model_clear();
    hist.delete();
    e_vld = 0; e_cout = 0; e_ovf = 0; e_sum = '0; e_txn = '0; e_ovfc = '0;
  endtask

  // Drive one cycle, let the edge happen, advance the model; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                     input logic c, input logic clr = 1'b0);
    rec_t r;
    valid_in = v; a = aa; b = bb; cin = c; stats_clr = clr;
    @(posedge clk);
    if (STATS) begin
      if (clr) begin e_txn = '0; e_ovfc = '0; end
      else if (e_vld) begin
        if (e_txn != 32'hFFFF_FFFF) e_txn++;
        if (e_ovf && e_ovfc != 32'hFFFF_FFFF) e_ovfc++;
      end
    end
    r = '{v, aa, bb, c};
    hist.push_back(r);
    e_vld = 0;
    if (hist.size() == 4) begin
      r = hist.pop_front();
      if (r.v) begin
        e_vld = 1;
        {e_ovf, e_cout, e_sum} = ref_add(r.a, r.b, r.c);
      end
    end
    #1;
    valid_in = 1'b0; stats_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom); stats_clr = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({valid_out, sum, cout, ovf, txn_cnt, ovf_cnt} !== '0) begin
        failures++;
        $display("FAIL reset_state: v=%0b sum=%h cout=%0b ovf=%0b txn=%0d ovfc=%0d, required all 0",
                 valid_out, sum, cout, ovf, txn_cnt, ovf_cnt);
      end
    end
    valid_in = 1'b0; stats_clr = 1'b0;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_carry_ripple();
    cyc(1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid_out !== 1'b0) begin
        failures++; $display("FAIL ripple_early: valid_out=%0b after %0d edges, required 0", valid_out, i + 1);
      end
      cyc(1'b0, $urandom, $urandom, 1'($urandom));
    end
    checks++;
    if ({valid_out, cout, ovf, sum} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL ripple_result: v=%0b cout=%0b ovf=%0b sum=%h, required v=1 cout=1 ovf=0 sum=0", valid_out, cout, ovf, sum);
    end
    repeat (4) cyc(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_overflow();
    cyc(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    repeat (3) cyc(1'b0, $urandom, $urandom, 1'($urandom));
    checks++;
    if ({valid_out, cout, ovf, sum} !== {1'b1, 1'b0, 1'b1, 32'h8000_0000}) begin
      failures++;
      $display("FAIL overflow: v=%0b cout=%0b ovf=%0b sum=%h, required v=1 cout=0 ovf=1 sum=80000000", valid_out, cout, ovf, sum);
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b0);
    checks++;
    if ({valid_out, ovf, sum} !== {1'b0, 1'b1, 32'h8000_0000}) begin
      failures++; $display("FAIL overflow_hold: v=%0b ovf=%0b sum=%h, required v=0 ovf=1 sum=80000000", valid_out, ovf, sum);
    end
    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs[3] = '{32'd3, 32'd7, 32'd0};
    logic        xc[3] = '{1'b0, 1'b0, 1'b1};
    logic        xo[3] = '{1'b0, 1'b0, 1'b1};
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b1, 32'd1, 32'd2, 1'b0);
    cyc(1'b1, 32'd3, 32'd4, 1'b0);
    cyc(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if ({valid_out, cout, ovf, sum} !== {1'b1, xc[i], xo[i], xs[i]}) begin
        failures++;
        $display("FAIL b2b_result[%0d]: v=%0b cout=%0b ovf=%0b sum=%h, required v=1 cout=%0b ovf=%0b sum=%h",
                 i, valid_out, cout, ovf, sum, xc[i], xo[i], xs[i]);
      end
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b0);
    checks++;
    if ({valid_out, txn_cnt, ovf_cnt} !== {1'b0, (STATS ? 32'd3 : 32'd0), (STATS ? 32'd1 : 32'd0)}) begin
      failures++;
      $display("FAIL b2b_stats: v=%0b txn=%0d ovfc=%0d, required v=0 txn=%0d ovfc=%0d",
               valid_out, txn_cnt, ovf_cnt, STATS ? 3 : 0, STATS ? 1 : 0);
    end
    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_bubbles();
    logic xv[3] = '{1'b1, 1'b0, 1'b1};
    cyc(1'b1, 32'd5, 32'd5, 1'b0);
    cyc(1'b0, $urandom, $urandom, 1'b1);
    cyc(1'b1, 32'd9, 32'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, $urandom, $urandom, 1'($urandom));
      checks++;
      if ({valid_out, sum} !== {xv[i], 32'd10}) begin
        failures++; $display("FAIL bubble[%0d]: v=%0b sum=%0d, required v=%0b sum=10", i, valid_out, sum, xv[i]);
      end
    end
    repeat (4) cyc(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: x = 32'hFFFF_FFFF; 1: x = 32'h8000_0000; 2: x = 32'h7FFF_FFFF; default: x = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: y = 32'hFFFF_FFFF; 1: y = 32'h8000_0000; 2: y = 32'h0000_0001; default: y = $urandom;
      endcase
      cyc($urandom_range(0, 9) < 7, x, y, 1'($urandom), $urandom_range(0, 19) == 0);
      checks++;
      if ({valid_out, cout, ovf, sum, txn_cnt, ovf_cnt} !== {e_vld, e_cout, e_ovf, e_sum, e_txn, e_ovfc}) begin
        failures++;
        $display("FAIL random[%0d]: v=%0b cout=%0b ovf=%0b sum=%h txn=%0d ovfc=%0d, required v=%0b cout=%0b ovf=%0b sum=%h txn=%0d ovfc=%0d",
                 i, valid_out, cout, ovf, sum, txn_cnt, ovf_cnt, e_vld, e_cout, e_ovf, e_sum, e_txn, e_ovfc);
      end
    end
    repeat (4) cyc(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    cyc(1'b1, $urandom, $urandom, 1'b1);
    cyc(1'b1, $urandom, $urandom, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_out, sum, cout, ovf, txn_cnt, ovf_cnt} !== '0) begin
      failures++; $display("FAIL async_reset: v=%0b sum=%h txn=%0d, required all 0", valid_out, sum, txn_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if ({valid_out, sum} !== {1'b0, 32'd0}) begin
        failures++; $display("FAIL flushed[%0d]: v=%0b sum=%h, required v=0 sum=0", i, valid_out, sum);
      end
    end
    cyc(1'b1, 32'd2, 32'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid_out !== 1'b0) begin
        failures++; $display("FAIL post_reset_early[%0d]: valid_out=%0b, required 0", i, valid_out);
      end
      cyc(1'b0, 32'd0, 32'd0, 1'b0);
    end
    checks++;
    if ({valid_out, sum, cout} !== {1'b1, 32'd4, 1'b0}) begin
      failures++; $display("FAIL post_reset_txn: v=%0b sum=%0d cout=%0b, required v=1 sum=4 cout=0", valid_out, sum, cout);
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (txn_cnt !== (STATS ? 32'd1 : 32'd0)) begin
      failures++; $display("FAIL stats_count: txn=%0d, required %0d", txn_cnt, STATS ? 1 : 0);
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    checks++;
    if ({txn_cnt, ovf_cnt} !== 64'd0) begin
      failures++; $display("FAIL stats_clr: txn=%0d ovfc=%0d, required 0 0", txn_cnt, ovf_cnt);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_back_to_back();
    test_bubbles();
    test_random();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
Pipelined ripple-chunk adder; the responder (DUT) end of the adder_if protocol (valid_in/a/b/cin in, valid_out/sum/cout/ovf out).
- Operands are split into CHUNK_W-bit chunks; chunk k is added in pipeline stage k, with the carry registered between stages.
- Throughput: one transaction per cycle. Latency: NUM_STAGES = DATA_WIDTH/CHUNK_W.
- No backpressure: the protocol has no ready signal.

Parameters:
- DATA_WIDTH, 32, operand/sum width.
- CHUNK_W, 8, bits added per stage. DATA_WIDTH % CHUNK_W != 0 is an elaboration-time $error. CHUNK_W == DATA_WIDTH gives a single-stage (latency 1) adder.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  transaction qualifier for a/b/cin.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B.
- cin  input  1  carry in.
- valid_out  output  1  one-cycle pulse per completed transaction.
- sum  output  DATA_WIDTH  a+b+cin, modulo 2^DATA_WIDTH.
- cout  output  1  carry out of bit DATA_WIDTH-1.
- ovf  output  1  signed (two's-complement) overflow.
- stats_clr  input  1  synchronous clear of the stats counters (see Optional Feature).
- txn_cnt  output  32  completed-transaction count.
- ovf_cnt  output  32  count of completed transactions with ovf=1.

Behaviour:
- Reset: while rst_n=0, all pipeline registers, valid_out, sum, cout, ovf, txn_cnt and ovf_cnt are 0. Reset takes effect immediately (async); release is sampled on clk.
- Pipeline: per-stage valid bit v[k]; v[0] <= valid_in; v[k] <= v[k-1]; valid_out = v[NUM_STAGES-1].
- Data capture: stage k data/carry registers load only when the incoming valid is 1; otherwise they hold their value.
- Result hold: sum/cout/ovf keep the last valid result while valid_out=0.
- Skew: operand chunks not yet consumed travel in delay registers alongside the transaction. Completed sum chunks travel in de-skew registers. The full sum is presented aligned on the valid_out cycle.
- Stage k: {c[k+1], s_chunk} = a_chunk + b_chunk + c[k], with c[0] = cin; cout = c[NUM_STAGES].
- Overflow: ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]). Operand MSBs are carried down the pipe for this calculation.
- Latency: valid_in=1 sampled at edge N produces valid_out=1 after edge N+NUM_STAGES-1, i.e. during cycle N+NUM_STAGES relative to input presentation. This is exactly NUM_STAGES cycles, no variation.
- Ordering: strictly in order; back-to-back inputs give back-to-back outputs; input bubbles are reproduced exactly at the output.
- Reset mid-operation: all in-flight transactions are discarded; no valid_out is produced for them after release. The first post-reset transaction has normal latency.
- X handling: a/b/cin are don't-care when valid_in=0 and must not propagate into sum.

Optional Feature:
- Macro: ADDER_PIPE_STATS_EN.
- Defined:
  - txn_cnt increments on each valid_out.
  - ovf_cnt increments on each valid_out && ovf.
  - Both saturate at 32'hFFFF_FFFF.
  - stats_clr=1 zeroes both counters next edge; clear wins over a simultaneous increment.
- Undefined: txn_cnt and ovf_cnt are tied to 0; stats_clr is ignored; no counter flops.

Decomposition:
- Shared package adder_pipe_pkg:
  - localparam/function num_stages(DATA_WIDTH, CHUNK_W).
  - typedef stage_ctl_t {valid, carry, a_msb, b_msb}.
  - STATS_W = 32.
- Natural sub-module adder_pipe_stage: one chunk add plus registered carry/valid, generated NUM_STAGES times.
- Skew/de-skew delay lines stay in the top level.

Test Plan (DATA_WIDTH=32, CHUNK_W=8, latency 4):
1. rst_n=0 with random inputs toggling -> valid_out, sum, cout, ovf, txn_cnt and ovf_cnt all 0.
2. a=32'hFFFF_FFFF, b=0, cin=1 -> 4 cycles later: sum=0, cout=1, ovf=0 (carry ripples through all 4 stages).
3. a=32'h7FFF_FFFF, b=1, cin=0 -> sum=32'h8000_0000, cout=0, ovf=1.
4. Back-to-back 1+2, 3+4, 32'h8000_0000+32'h8000_0000 -> valid_out high 3 consecutive cycles, in order: 3; 7; then sum=0, cout=1, ovf=1. With stats: txn_cnt=3, ovf_cnt=1.
5. valid_in pattern 1,0,1 (5+5, x, 9+1) -> valid_out pattern 1,0,1; sum=10, held 10 during the gap, then 10.
6. rst_n pulsed low with 2 transactions in flight -> no valid_out after release. A new txn 2+2 yields sum=4 exactly 4 cycles later. stats_clr pulse zeroes both counters.
